// File: rtl/riscv_mc_controller.sv
// rtl/riscv_mc_controller.sv - multi-cycle RV32I control FSM with shared memory port arbitration
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, counts retires, traps on bad opcode or memory timeout.
module riscv_mc_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_src_o,
  output logic [3:0]       alu_op_o,
  output logic             alu_src_b_o,
  output logic             reg_we_o,
  output logic             wb_sel_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // Counter only has to hold values up to MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             trap_q;
  logic [1:0]       cause_q, cause_d;
  logic             retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_br, legal;
  logic [3:0] alu_op_dec;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_br  = (opcode == OP_BR);
  assign legal  = is_r | is_i | is_lw | is_sw | is_br;
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  // ALU control decoded from the IR; the IR is stable from DECODE through WB so alu_op is too.
  always_comb begin
    alu_op_dec = 4'b0000;
    if (is_r)       alu_op_dec = {instr_i[30], funct3};
    else if (is_i)  alu_op_dec = {instr_i[30] & (funct3 == 3'b101), funct3};
    else if (is_br) alu_op_dec = 4'b1000;
  end

  // Next-state and strobe decode; memory strobes stay constant for the whole request until ready.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = '0;
    cause_d     = cause_q;
    retire      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = 1'b0;
    alu_op_o    = 4'b0000;
    alu_src_b_o = 1'b0;
    reg_we_o    = 1'b0;
    wb_sel_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = S_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_op_o = alu_op_dec;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        alu_op_o    = alu_op_dec;
        alu_src_b_o = ~(is_r | is_br);
        if (is_r || is_i) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_br) begin
          if (zero_i ^ instr_i[12]) begin
            pc_we_o  = 1'b1;
            pc_src_o = 1'b1;
          end
          retire  = 1'b1;
          state_d = run_i ? S_FETCH : S_IDLE;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_MEM: begin
        alu_op_o  = alu_op_dec;
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = is_sw;
        if (mem_ready_i) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = run_i ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        alu_op_o = alu_op_dec;
        reg_we_o = 1'b1;
        wb_sel_o = is_lw;
        retire   = 1'b1;
        state_d  = run_i ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, timeout counter, retire counter and sticky trap registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_q + CNT_W'(retire);
      trap_q    <= trap_q | (state_d == S_TRAP);
      cause_q   <= cause_d;
    end
  end

  assign state_o      = state_q;
  assign retired_o    = retired_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb/tb_riscv_mc_controller.sv - scoreboard bench for riscv_mc_controller
// Stimulus pushes a per-cycle expected output vector; a monitor pops and compares at each falling edge.
module tb_riscv_mc_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b, reg_we, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        trap;
  logic [1:0]  trap_cause;

  riscv_mc_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i(clk), .reset_i(reset_n), .run_i(run), .instr_i(instr), .zero_i(zero),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we), .iord_o(iord),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src), .alu_op_o(alu_op),
    .alu_src_b_o(alu_src_b), .reg_we_o(reg_we), .wb_sel_o(wb_sel), .state_o(state),
    .retired_o(retired), .trap_o(trap), .trap_cause_o(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [8:0]  sb;
    logic [3:0]  aop;
    logic [31:0] ret;
    logic [2:0]  trp;
  } vec_t;

  // strobe field order: mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b, reg_we, wb_sel
  localparam logic [8:0] X_NO = 9'b000000000;
  localparam logic [8:0] X_FW = 9'b100000000;
  localparam logic [8:0] X_FR = 9'b100110000;
  localparam logic [8:0] X_IB = 9'b000000100;
  localparam logic [8:0] X_BT = 9'b000011000;
  localparam logic [8:0] X_ML = 9'b101000000;
  localparam logic [8:0] X_MS = 9'b111000000;
  localparam logic [8:0] X_WR = 9'b000000010;
  localparam logic [8:0] X_WL = 9'b000000011;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4050D193;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  vec_t exp_q[$];
  int   tag_q[$];
  int   tag_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   active = 1'b0;

  task automatic step(input logic rn, input logic rr, input logic [31:0] ins, input logic z,
                      input logic rdy, input logic [2:0] st, input logic [8:0] s,
                      input logic [3:0] a, input logic [31:0] ret, input logic [2:0] t);
    vec_t v;
    @(posedge clk);
    #1;
    reset_n   = rn;
    run       = rr;
    instr     = ins;
    zero      = z;
    mem_ready = rdy;
    v.st = st; v.sb = s; v.aop = a; v.ret = ret; v.trp = t;
    exp_q.push_back(v);
    tag_q.push_back(tag_n);
    tag_n++;
    active = 1'b1;
  endtask

  // Monitor: one expected vector per active cycle, compared away from the rising edge.
  initial begin
    vec_t act, ex;
    int   tg;
    forever begin
      @(negedge clk);
      if (active) begin
        act.st  = state;
        act.sb  = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b, reg_we, wb_sel};
        act.aop = alu_op;
        act.ret = retired;
        act.trp = {trap, trap_cause};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_underflow: got st=%0d sb=%b but no expected vector queued", act.st, act.sb);
        end else begin
          ex = exp_q.pop_front();
          tg = tag_q.pop_front();
          if (act !== ex) begin
            n_bad++;
            $display("FAIL cycle%0d: got st=%0d sb=%b aop=%b ret=%0d trp=%b want st=%0d sb=%b aop=%b ret=%0d trp=%b",
                     tg, act.st, act.sb, act.aop, act.ret, act.trp, ex.st, ex.sb, ex.aop, ex.ret, ex.trp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    // reset state
    step(0,0,32'h0,0,0, 3'd0,X_NO,4'h0,0,3'b000);
    // ADD, ready on first request cycle
    step(1,1,I_ADD,0,0, 3'd0,X_NO,4'h0,0,3'b000);
    step(1,0,I_ADD,0,1, 3'd1,X_FR,4'h0,0,3'b000);
    step(1,0,I_ADD,0,0, 3'd2,X_NO,4'h0,0,3'b000);
    step(1,0,I_ADD,0,0, 3'd3,X_NO,4'h0,0,3'b000);
    step(1,0,I_ADD,0,0, 3'd5,X_WR,4'h0,0,3'b000);
    step(1,1,I_SUB,0,0, 3'd0,X_NO,4'h0,1,3'b000);
    // SUB then SRAI back to back
    step(1,0,I_SUB,0,1, 3'd1,X_FR,4'h0,1,3'b000);
    step(1,0,I_SUB,0,0, 3'd2,X_NO,4'h8,1,3'b000);
    step(1,0,I_SUB,0,0, 3'd3,X_NO,4'h8,1,3'b000);
    step(1,1,I_SUB,0,0, 3'd5,X_WR,4'h8,1,3'b000);
    step(1,0,I_SRAI,0,1, 3'd1,X_FR,4'h0,2,3'b000);
    step(1,0,I_SRAI,0,0, 3'd2,X_NO,4'hD,2,3'b000);
    step(1,0,I_SRAI,0,0, 3'd3,X_IB,4'hD,2,3'b000);
    step(1,0,I_SRAI,0,0, 3'd5,X_WR,4'hD,2,3'b000);
    step(1,1,I_LW,0,0, 3'd0,X_NO,4'h0,3,3'b000);
    // LW: one fetch wait, stray ready ignored, three MEM waits
    step(1,0,I_LW,0,0, 3'd1,X_FW,4'h0,3,3'b000);
    step(1,0,I_LW,0,1, 3'd1,X_FR,4'h0,3,3'b000);
    step(1,0,I_LW,0,1, 3'd2,X_NO,4'h0,3,3'b000);
    step(1,0,I_LW,0,1, 3'd3,X_IB,4'h0,3,3'b000);
    for (int i = 0; i < 3; i++) step(1,0,I_LW,0,0, 3'd4,X_ML,4'h0,3,3'b000);
    step(1,0,I_LW,0,1, 3'd4,X_ML,4'h0,3,3'b000);
    step(1,0,I_LW,0,0, 3'd5,X_WL,4'h0,3,3'b000);
    step(1,1,I_BEQ,0,0, 3'd0,X_NO,4'h0,4,3'b000);
    // BEQ taken, BNE not taken
    step(1,0,I_BEQ,0,1, 3'd1,X_FR,4'h0,4,3'b000);
    step(1,0,I_BEQ,0,0, 3'd2,X_NO,4'h8,4,3'b000);
    step(1,1,I_BEQ,1,0, 3'd3,X_BT,4'h8,4,3'b000);
    step(1,0,I_BNE,0,1, 3'd1,X_FR,4'h0,5,3'b000);
    step(1,0,I_BNE,0,0, 3'd2,X_NO,4'h8,5,3'b000);
    step(1,0,I_BNE,1,0, 3'd3,X_NO,4'h8,5,3'b000);
    step(1,1,I_SW,0,0, 3'd0,X_NO,4'h0,6,3'b000);
    // SW retires from MEM
    step(1,0,I_SW,0,1, 3'd1,X_FR,4'h0,6,3'b000);
    step(1,0,I_SW,0,0, 3'd2,X_NO,4'h0,6,3'b000);
    step(1,0,I_SW,0,0, 3'd3,X_IB,4'h0,6,3'b000);
    step(1,0,I_SW,0,1, 3'd4,X_MS,4'h0,6,3'b000);
    step(1,1,I_LW,0,0, 3'd0,X_NO,4'h0,7,3'b000);
    // ready on the last permitted fetch cycle wins over timeout; then reset mid-MEM
    for (int i = 0; i < 15; i++) step(1,0,I_LW,0,0, 3'd1,X_FW,4'h0,7,3'b000);
    step(1,0,I_LW,0,1, 3'd1,X_FR,4'h0,7,3'b000);
    step(1,0,I_LW,0,0, 3'd2,X_NO,4'h0,7,3'b000);
    step(1,0,I_LW,0,0, 3'd3,X_IB,4'h0,7,3'b000);
    step(1,0,I_LW,0,0, 3'd4,X_ML,4'h0,7,3'b000);
    step(0,0,I_LW,0,0, 3'd4,X_ML,4'h0,7,3'b000);
    step(1,1,I_ILL,0,0, 3'd0,X_NO,4'h0,0,3'b000);
    // illegal opcode trap, absorbing until reset
    step(1,0,I_ILL,0,1, 3'd1,X_FR,4'h0,0,3'b000);
    step(1,1,I_ILL,0,1, 3'd2,X_NO,4'h0,0,3'b000);
    for (int i = 0; i < 3; i++) step(1,1,I_ILL,0,1, 3'd7,X_NO,4'h0,0,3'b101);
    step(0,0,I_ILL,0,0, 3'd7,X_NO,4'h0,0,3'b101);
    step(1,1,I_ADD,0,0, 3'd0,X_NO,4'h0,0,3'b000);
    // fetch timeout after 16 request cycles
    for (int i = 0; i < 16; i++) step(1,0,I_ADD,0,0, 3'd1,X_FW,4'h0,0,3'b000);
    for (int i = 0; i < 2; i++) step(1,1,I_ADD,0,1, 3'd7,X_NO,4'h0,0,3'b110);
    step(0,0,I_ADD,0,0, 3'd7,X_NO,4'h0,0,3'b110);
    step(1,0,32'h0,0,0, 3'd0,X_NO,4'h0,0,3'b000);
    @(negedge clk);
    #1;
    active = 1'b0;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expected vectors left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
